// File: rtl/counter_pkg.sv
// Shared types and constants for the counter run/direction controller.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ctrl_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // One-cycle pulse on the accepted 0->1 transition; releases are silent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run/direction sequencer for counter_top with optional ping-pong auto-reverse.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_dir,
    input  logic             bounce_en,
    input  logic [WIDTH-1:0] count,
    output logic             enable,
    output logic             dir,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic        run_press;
    logic        dir_press;
    logic        run_level;
    logic        dir_level;
    logic        unused_levels;

    logic        limit_hit;
    logic        dir_toggle;

    ctrl_state_t state_q;
    ctrl_state_t state_next;
    logic        dir_r;
    logic        dir_next;
    logic        enable_next;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_run_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_run),
        .level   (run_level),
        .press   (run_press)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_dir_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_dir),
        .level   (dir_level),
        .press   (dir_press)
    );

    // Debounced levels are only needed by the press detectors.
    assign unused_levels = run_level ^ dir_level;

    // Limit detection and the single combined direction toggle.
    always_comb begin
        limit_hit  = bounce_en &&
                     (((state_q == UP)   && (count == COUNT_MAX)) ||
                      ((state_q == DOWN) && (count == '0)));
        dir_toggle = dir_press | limit_hit;
    end

    // Next state, next direction and next enable.
    always_comb begin
        state_next  = state_q;
        dir_next    = dir_r ^ dir_toggle;
        enable_next = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_press) begin
                    state_next = (dir_next == DIR_UP) ? UP : DOWN;
                end
            end
            UP: begin
                if (run_press) begin
                    state_next = IDLE;
                end else if (dir_toggle) begin
                    state_next = DOWN;
                end
            end
            DOWN: begin
                if (run_press) begin
                    state_next = IDLE;
                end else if (dir_toggle) begin
                    state_next = UP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        enable_next = (state_next == UP) || (state_next == DOWN);
    end

    // State, direction and enable registers; outputs come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_r   <= DIR_UP;
            enable  <= 1'b0;
        end else begin
            state_q <= state_next;
            dir_r   <= dir_next;
            enable  <= enable_next;
        end
    end

    assign dir   = dir_r;
    assign state = 2'(state_q);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random stimulus vs. an event-level model.
module tb_counter_ctrl;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned DEBOUNCE = 4;
    localparam int          MAXC     = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             btn_run;
    logic             btn_dir;
    logic             bounce_en;
    logic [WIDTH-1:0] count;
    logic             enable;
    logic             dir;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: running flag + direction; state is implied (idle, or the direction's run state).
    bit m_running;
    bit m_dir;
    int m_state;
    // Per button (0 = run, 1 = dir): 2-cycle sync delay, window of delayed samples,
    // accepted level, and a 2-stage pipe from acceptance to action.
    bit d0 [2];
    bit d1 [2];
    bit hist [2][DEBOUNCE];
    bit lvl [2];
    bit p0 [2];
    bit p1 [2];

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_run   (btn_run),
        .btn_dir   (btn_dir),
        .bounce_en (bounce_en),
        .count     (count),
        .enable    (enable),
        .dir       (dir),
        .state     (state)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running = 1'b0;
        m_dir     = 1'b1;
        m_state   = 0;
        for (int b = 0; b < 2; b++) begin
            d0[b]  = 1'b0;
            d1[b]  = 1'b0;
            lvl[b] = 1'b0;
            p0[b]  = 1'b0;
            p1[b]  = 1'b0;
            for (int k = 0; k < DEBOUNCE; k++) hist[b][k] = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs as they stand at that edge.
    task automatic model_edge();
        bit raw [2];
        bit run_act;
        bit dir_act;
        bit limit;
        bit dl;
        bit all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        run_act = p1[0];
        dir_act = p1[1];
        limit = bounce_en && ((m_state == 1 && int'(count) == MAXC) ||
                              (m_state == 2 && int'(count) == 0));
        m_dir = m_dir ^ (dir_act | limit);
        if (run_act) m_running = !m_running;
        m_state = !m_running ? 0 : (m_dir ? 1 : 2);

        raw[0] = btn_run;
        raw[1] = btn_dir;
        for (int b = 0; b < 2; b++) begin
            dl    = d1[b];
            d1[b] = d0[b];
            d0[b] = raw[b];
            for (int k = DEBOUNCE - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = dl;
            all_diff = 1'b1;
            for (int k = 0; k < DEBOUNCE; k++) if (hist[b][k] == lvl[b]) all_diff = 1'b0;
            p1[b] = p0[b];
            p0[b] = 1'b0;
            if (all_diff) begin
                p0[b]  = !lvl[b];
                lvl[b] = !lvl[b];
            end
        end
    endtask

    // One clock: model follows the rising edge, DUT compared on the falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("model_enable", int'(enable), int'(m_running));
            chk("model_dir", int'(dir), int'(m_dir));
            chk("model_state", int'(state), m_state);
        end
    endtask

    task automatic tap_run();
        btn_run = 1'b1;
        step(8);
        btn_run = 1'b0;
        step(8);
    endtask

    task automatic tap_dir();
        btn_dir = 1'b1;
        step(8);
        btn_dir = 1'b0;
        step(8);
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_enable", int'(enable), 0);
        chk("async_rst_dir", int'(dir), 1);
        chk("async_rst_state", int'(state), 0);
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        btn_run   = 1'b0;
        btn_dir   = 1'b0;
        bounce_en = 1'b0;
        count     = WIDTH'(5);
        model_reset();

        // Reset state
        step(10);
        reset = 1'b0;
        step(1);
        chk("rst_enable", int'(enable), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_state", int'(state), 0);

        // Run press latency, hold, release, second press
        btn_run = 1'b1;
        step(7);
        chk("run_before_edge7", int'(enable), 0);
        step(1);
        chk("run_enable_edge7", int'(enable), 1);
        chk("run_state_edge7", int'(state), 1);
        step(12);
        chk("run_held", int'(state), 1);
        btn_run = 1'b0;
        step(10);
        chk("run_release", int'(state), 1);
        btn_run = 1'b1;
        step(10);
        chk("run_stop_state", int'(state), 0);
        chk("run_stop_enable", int'(enable), 0);
        btn_run = 1'b0;
        step(10);

        // Async reset while running
        tap_run();
        chk("rerun_state", int'(state), 1);
        mid_reset();
        step(2);

        // Dir glitch, then a real dir press while running
        tap_run();
        btn_dir = 1'b1;
        step(3);
        btn_dir = 1'b0;
        step(10);
        chk("glitch_dir", int'(dir), 1);
        chk("glitch_state", int'(state), 1);
        btn_dir = 1'b1;
        step(10);
        chk("dirpress_dir", int'(dir), 0);
        chk("dirpress_state", int'(state), 2);
        chk("dirpress_enable", int'(enable), 1);
        btn_dir = 1'b0;
        step(8);

        // Bounce at the top and bottom limits
        tap_dir();
        chk("back_up_state", int'(state), 1);
        bounce_en = 1'b1;
        count = WIDTH'(14);
        step(1);
        chk("lim14_state", int'(state), 1);
        count = WIDTH'(15);
        step(1);
        chk("lim15_state", int'(state), 2);
        chk("lim15_dir", int'(dir), 0);
        step(19);
        chk("lim15_held_state", int'(state), 2);
        count = WIDTH'(1);
        step(1);
        chk("lim1_state", int'(state), 2);
        count = WIDTH'(0);
        step(1);
        chk("lim0_state", int'(state), 1);
        chk("lim0_dir", int'(dir), 1);
        step(10);
        chk("lim0_held_state", int'(state), 1);
        count = WIDTH'(5);
        bounce_en = 1'b0;
        step(1);

        // Simultaneous run + dir press from IDLE
        tap_run();
        chk("idle_again", int'(state), 0);
        btn_run = 1'b1;
        btn_dir = 1'b1;
        step(8);
        btn_run = 1'b0;
        btn_dir = 1'b0;
        step(8);
        chk("both_state", int'(state), 2);
        chk("both_dir", int'(dir), 0);
        chk("both_enable", int'(enable), 1);

        // Dir press coinciding with a limit hit
        tap_dir();
        chk("coinc_pre_state", int'(state), 1);
        bounce_en = 1'b1;
        count = WIDTH'(14);
        btn_dir = 1'b1;
        step(7);
        chk("coinc_before", int'(state), 1);
        count = WIDTH'(15);
        step(1);
        chk("coinc_state", int'(state), 2);
        chk("coinc_dir", int'(dir), 0);
        btn_dir = 1'b0;
        count = WIDTH'(7);
        bounce_en = 1'b0;
        step(10);
        chk("coinc_settled", int'(dir), 0);

        // Dir presses in IDLE select the next run direction
        tap_run();
        chk("idle3_state", int'(state), 0);
        tap_dir();
        chk("idle_dir1", int'(dir), 1);
        tap_dir();
        chk("idle_dir0", int'(dir), 0);
        chk("idle_dir0_enable", int'(enable), 0);
        tap_run();
        chk("idle_run_down", int'(state), 2);
        chk("idle_run_enable", int'(enable), 1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 7) == 0) btn_dir = ~btn_dir;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       count = '0;
                    1:       count = '1;
                    default: count = WIDTH'($urandom);
                endcase
            end
            if ($urandom_range(0, 49) == 0) bounce_en = ~bounce_en;
            if ($urandom_range(0, 499) == 0) mid_reset();
            else step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
